// File: rtl/arch_pkg.sv
// Shared operand-path definitions for the core: operand width, slot limit
// and the operand scalar type.
package arch_pkg;
    localparam int OPERAND_W = 8;
    localparam int MAX_SLOTS = 8;

    typedef logic [OPERAND_W-1:0] operand_t;
endpackage

// File: rtl/operand_compactor.sv
// Combinational shift-down network: drops the lowest cons_i slots and moves
// the remaining occupied slots to the bottom, zero-filling vacated slots.
module operand_compactor
    import arch_pkg::*;
#(
    parameter int WIDTH = OPERAND_W,
    parameter int SLOTS = 3,
    parameter int CNT_W = $clog2(SLOTS + 1)
) (
    input  logic [SLOTS*WIDTH-1:0] slots_i,
    input  logic [SLOTS-1:0]       valid_i,
    input  logic [CNT_W-1:0]       cons_i,
    output logic [SLOTS*WIDTH-1:0] slots_o,
    output logic [SLOTS-1:0]       valid_o
);

    // Destination i takes source i+cons; data is masked by valid so that
    // empty slots always read as zero.
    always_comb begin
        slots_o = '0;
        valid_o = '0;
        for (int i = 0; i < SLOTS; i++) begin
            for (int j = 0; j < SLOTS; j++) begin
                if ((j == i + int'(cons_i)) && valid_i[j]) begin
                    valid_o[i]                = 1'b1;
                    slots_o[i*WIDTH +: WIDTH] = slots_i[j*WIDTH +: WIDTH];
                end
            end
        end
    end

endmodule

// File: rtl/operand_queue.sv
// Ordered operand slots fed by put instructions; a firing op consumes
// op_need operands from the head, then any concurrent put is appended.
module operand_queue
    import arch_pkg::*;
#(
    parameter int WIDTH = OPERAND_W,
    parameter int SLOTS = 3,
    parameter int CNT_W = $clog2(SLOTS + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   put_en,
    input  logic [WIDTH-1:0]       put_value,
    input  logic                   op_en,
    input  logic [CNT_W-1:0]       op_need,
    input  logic                   clr_err,
    output logic [SLOTS*WIDTH-1:0] slot_data,
    output logic [SLOTS-1:0]       slot_valid,
    output logic [CNT_W-1:0]       count,
    output logic                   full,
    output logic                   ready,
    output logic                   op_stall,
    output logic                   overflow,
    output logic                   underflow
);

    localparam int CW1 = CNT_W + 1;
    typedef logic [CW1-1:0] cnt_ext_t;
    localparam cnt_ext_t SLOTS_EXT = cnt_ext_t'(SLOTS);

    logic [SLOTS*WIDTH-1:0] slots_q, slots_d;
    logic [SLOTS-1:0]       valid_q, valid_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   ovf_q, ovf_d;
    logic                   udf_q, udf_d;

    logic [CNT_W-1:0]       cons;
    cnt_ext_t               after_cons;
    logic                   push_ok;
    logic [SLOTS*WIDTH-1:0] comp_slots;
    logic [SLOTS-1:0]       comp_valid;

    // Extended-width compare so op_need values beyond the slot count
    // simply never become ready.
    assign ready    = {1'b0, count_q} >= {1'b0, op_need};
    assign op_stall = op_en & ~ready;
    assign full     = ({1'b0, count_q} == SLOTS_EXT);

    assign cons       = (op_en && ready) ? op_need : '0;
    assign after_cons = {1'b0, count_q} - {1'b0, cons};
    assign push_ok    = put_en && (after_cons < SLOTS_EXT);

    operand_compactor #(
        .WIDTH (WIDTH),
        .SLOTS (SLOTS),
        .CNT_W (CNT_W)
    ) u_compactor (
        .slots_i (slots_q),
        .valid_i (valid_q),
        .cons_i  (cons),
        .slots_o (comp_slots),
        .valid_o (comp_valid)
    );

    // Append lands in the first free slot after compaction.
    always_comb begin
        slots_d = comp_slots;
        valid_d = comp_valid;
        for (int i = 0; i < SLOTS; i++) begin
            if (push_ok && (after_cons == cnt_ext_t'(i))) begin
                slots_d[i*WIDTH +: WIDTH] = put_value;
                valid_d[i]                = 1'b1;
            end
        end
        count_d = after_cons[CNT_W-1:0] + {{(CNT_W-1){1'b0}}, push_ok};
    end

    // Sticky flags: a new error in the same cycle as clr_err takes priority.
    always_comb begin
        ovf_d = ovf_q;
        udf_d = udf_q;
        if (clr_err) begin
            ovf_d = 1'b0;
            udf_d = 1'b0;
        end
        if (put_en && !push_ok) ovf_d = 1'b1;
        if (op_stall)           udf_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            slots_q <= '0;
            valid_q <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            slots_q <= slots_d;
            valid_q <= valid_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    assign slot_data  = slots_q;
    assign slot_valid = valid_q;
    assign count      = count_q;
    assign overflow   = ovf_q;
    assign underflow  = udf_q;

endmodule

// File: tb/tb_operand_queue.sv
// Directed test of operand_queue with SLOTS=3, WIDTH=8: fill, overflow,
// compaction, concurrent consume/push, underflow stall, reset mid-operation.
module tb_operand_queue;

    logic        clk;
    logic        reset;
    logic        put_en;
    logic [7:0]  put_value;
    logic        op_en;
    logic [1:0]  op_need;
    logic        clr_err;
    logic [23:0] slot_data;
    logic [2:0]  slot_valid;
    logic [1:0]  count;
    logic        full;
    logic        ready;
    logic        op_stall;
    logic        overflow;
    logic        underflow;

    int n_checks = 0;
    int n_errors = 0;

    operand_queue #(
        .WIDTH (8),
        .SLOTS (3)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .put_en     (put_en),
        .put_value  (put_value),
        .op_en      (op_en),
        .op_need    (op_need),
        .clr_err    (clr_err),
        .slot_data  (slot_data),
        .slot_valid (slot_valid),
        .count      (count),
        .full       (full),
        .ready      (ready),
        .op_stall   (op_stall),
        .overflow   (overflow),
        .underflow  (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        put_en    = 1'b0;
        put_value = 8'h00;
        op_en     = 1'b0;
        op_need   = 2'd0;
        clr_err   = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic push(input logic [7:0] v);
        put_en    = 1'b1;
        put_value = v;
        tick();
    endtask

    task automatic fire(input logic [1:0] need);
        op_en   = 1'b1;
        op_need = need;
        tick();
    endtask

    initial begin
        idle();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_data",  slot_data,  24'h000000);
        check("rst_valid", slot_valid, 3'b000);
        check("rst_count", count,      2'd0);
        check("rst_full",  full,       1'b0);
        check("rst_ovf",   overflow,   1'b0);
        check("rst_udf",   underflow,  1'b0);
        check("rst_ready", ready,      1'b1);
        reset = 1'b1;

        // fill
        push(8'h11);
        push(8'h22);
        push(8'h33);
        check("fill_data",  slot_data,  24'h332211);
        check("fill_valid", slot_valid, 3'b111);
        check("fill_count", count,      2'd3);
        check("fill_full",  full,       1'b1);

        // overflow drops the value
        push(8'h44);
        check("ovf_data",  slot_data, 24'h332211);
        check("ovf_count", count,     2'd3);
        check("ovf_flag",  overflow,  1'b1);
        clr_err = 1'b1;
        tick();
        check("ovf_clr", overflow, 1'b0);

        // set beats clear
        put_en = 1'b1; put_value = 8'h44; clr_err = 1'b1;
        tick();
        check("ovf_set_wins", overflow, 1'b1);
        clr_err = 1'b1;
        tick();
        check("ovf_clr2", overflow, 1'b0);

        // partial consume
        op_en = 1'b1; op_need = 2'd2;
        #1;
        check("c2_ready", ready,    1'b1);
        check("c2_stall", op_stall, 1'b0);
        tick();
        check("c2_data",  slot_data,  24'h000033);
        check("c2_valid", slot_valid, 3'b001);
        check("c2_count", count,      2'd1);
        check("c2_full",  full,       1'b0);

        // consume the last one and append in the same cycle
        op_en = 1'b1; op_need = 2'd1; put_en = 1'b1; put_value = 8'h11;
        tick();
        check("swap_data",  slot_data, 24'h000011);
        check("swap_count", count,     2'd1);
        push(8'h22);
        push(8'h33);
        check("refill_data", slot_data, 24'h332211);

        // full queue consumes one and accepts a push
        op_en = 1'b1; op_need = 2'd1; put_en = 1'b1; put_value = 8'h55;
        tick();
        check("fullpush_data",  slot_data,  24'h553322);
        check("fullpush_count", count,      2'd3);
        check("fullpush_valid", slot_valid, 3'b111);
        check("fullpush_ovf",   overflow,   1'b0);

        // op_need==0 reads only
        op_en = 1'b1; op_need = 2'd0;
        #1;
        check("n0_ready", ready,    1'b1);
        check("n0_stall", op_stall, 1'b0);
        tick();
        check("n0_data",  slot_data, 24'h553322);
        check("n0_count", count,     2'd3);
        check("n0_udf",   underflow, 1'b0);

        fire(2'd2);
        check("c2b_data",  slot_data, 24'h000055);
        check("c2b_count", count,     2'd1);

        // insufficient operands: stall, flag, concurrent push still lands
        op_en = 1'b1; op_need = 2'd3; put_en = 1'b1; put_value = 8'h66;
        #1;
        check("uf_ready", ready,    1'b0);
        check("uf_stall", op_stall, 1'b1);
        tick();
        check("uf_data",  slot_data,  24'h006655);
        check("uf_valid", slot_valid, 3'b011);
        check("uf_count", count,      2'd2);
        check("uf_flag",  underflow,  1'b1);

        op_en = 1'b1; op_need = 2'd3; clr_err = 1'b1;
        tick();
        check("udf_set_wins", underflow, 1'b1);
        check("udf_hold_cnt", count,     2'd2);
        clr_err = 1'b1;
        tick();
        check("udf_clr", underflow, 1'b0);

        // empty queue underflow
        fire(2'd2);
        check("empty_count", count,      2'd0);
        check("empty_data",  slot_data,  24'h000000);
        check("empty_valid", slot_valid, 3'b000);
        op_en = 1'b1; op_need = 2'd1;
        #1;
        check("empty_stall", op_stall, 1'b1);
        tick();
        check("empty_udf",   underflow, 1'b1);
        check("empty_cnt2",  count,     2'd0);

        // reset overrides a concurrent op and push
        push(8'h77);
        push(8'h88);
        check("pre_rst_data",  slot_data, 24'h008877);
        check("pre_rst_count", count,     2'd2);
        reset = 1'b0; op_en = 1'b1; op_need = 2'd1; put_en = 1'b1; put_value = 8'h99;
        tick();
        check("mrst_data",  slot_data,  24'h000000);
        check("mrst_valid", slot_valid, 3'b000);
        check("mrst_count", count,      2'd0);
        check("mrst_ovf",   overflow,   1'b0);
        check("mrst_udf",   underflow,  1'b0);
        reset = 1'b1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/operand_queue.md
Name: operand_queue

Overview:
- Parametrised successor to the fixed three-register operand accumulator in the single-cycle core.
- Collects immediates pushed by "put" instructions into SLOTS ordered operand slots (slot 0 oldest; slots 0/1/2 map to the core's r0/r1/r2).
- A firing operation consumes a variable number of operands from the head and compacts the rest down.
- Sits between control (put_en/put_value/op_en/op_need) and the register file, data memory and PC_LUT, which read slot contents.

Parameters:
- WIDTH, 8, bits per operand slot.
- SLOTS, 3, number of operand slots (2..8).
- CNT_W, $clog2(SLOTS+1), width of count and op_need.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset; sampled on the rising edge of clk; slots clear when low.
- put_en  input  1  push put_value this cycle.
- put_value  input  WIDTH  operand to push.
- op_en  input  1  an operation fires this cycle and wants operands.
- op_need  input  CNT_W  operands the firing operation consumes (0..SLOTS).
- clr_err  input  1  clears the sticky error flags.
- slot_data  output  SLOTS*WIDTH  slot i at bits [i*WIDTH +: WIDTH]; registered.
- slot_valid  output  SLOTS  bit i = slot i holds an operand; registered; always thermometer (contiguous from bit 0).
- count  output  CNT_W  number of valid slots; registered.
- full  output  1  count == SLOTS (combinational from count).
- ready  output  1  count >= op_need (combinational).
- op_stall  output  1  op_en & ~ready (combinational); control holds the PC while high.
- overflow  output  1  sticky: a push was dropped.
- underflow  output  1  sticky: an op fired with insufficient operands.

Behaviour:
- Reset (reset==0 at posedge): slot_data=0, slot_valid=0, count=0, overflow=0, underflow=0. Reset overrides all other inputs.
- Latency: effects of put and op appear one cycle after the sampling edge. ready, full and op_stall follow count combinationally.
- Define cons = (op_en && ready) ? op_need : 0.
- Consume: slots cons..count-1 move to slots 0..count-cons-1. Vacated upper slots get valid=0 and data=0.
- Push (put_en):
  - Legal when count-cons < SLOTS. put_value is written to slot count-cons after compaction and count becomes count-cons+1.
  - Simultaneous op and put therefore yields the order: consume, then append.
- Full: put_en with count==SLOTS and cons==0 → value dropped, state unchanged, overflow<=1. If cons>0 the push is accepted, so a full queue can consume and push in the same cycle.
- Op with insufficient operands: op_en && count<op_need → nothing consumed, underflow<=1, op_stall=1. A put in the same cycle still applies.
- op_need==0: ready=1 and nothing consumed. This supports ops that only read slots, e.g. a branch tag in slot 2 kept for the next op.
- Empty: op_en with op_need>0 and count==0 → underflow case.
- clr_err: clears both sticky flags next cycle. If an error condition coincides with clr_err, the set wins.
- op_need > SLOTS: treated as never-ready. Each firing sets underflow.
- Width rules: count arithmetic is done in CNT_W+1 bits internally so no wrap occurs. No arithmetic is performed on slot data.

Decomposition:
- Shared package arch_pkg: OPERAND_W (=8), MAX_SLOTS, and the typedef operand_t = logic [OPERAND_W-1:0].
- One sub-module is natural: operand_compactor. It is a combinational shift-by-cons network taking slots/valid/cons and producing the compacted slots/valid. The top keeps the registers, push logic and flags.

Test Plan:
- Reset then fill: reset low 2 cycles; push 0x11, 0x22, 0x33 → slot_data {33,22,11}, slot_valid=3'b111, count=3, full=1.
- Overflow: full queue, push 0x44 with op_en=0 → queue unchanged, overflow=1. Then clr_err → overflow=0 next cycle.
- Partial consume with compaction: queue {11,22,33}, op_en=1, op_need=2 → slot0=0x33, slot_valid=3'b001, count=1.
- Simultaneous op and put at full: queue {11,22,33}, op_need=1, push 0x55 → {22,33,55}, count=3, overflow stays 0.
- Underflow stall: count=1, op_en=1, op_need=3 → op_stall=1 same cycle, underflow=1 next, slot contents unchanged. A concurrent push of 0x66 still lands in slot 1.
- Reset mid-operation: count=2 with op_en and put_en asserted while reset=0 → all outputs zero next cycle, flags cleared.
